// File: rtl/stopwatch_cpu_oci_dct_packer.sv
// Packs FRAG_W-bit trace fragments LSB-first into DEPTH-fragment words with a one-deep
// output register; a test_ending request flushes any partial word, then parks in DONE.
module stopwatch_cpu_oci_dct_packer #(
    parameter int unsigned FRAG_W = 2,
    parameter int unsigned DEPTH  = 15,
    parameter int unsigned CNT_W  = 4,
    localparam int unsigned BUF_W = FRAG_W * DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frag_valid,
    input  logic [FRAG_W-1:0] frag_data,
    output logic              frag_ready,
    input  logic              test_ending,
    output logic              dct_valid,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    input  logic              dct_ready,
    output logic              test_has_ended
);

    typedef enum logic [1:0] {StFill, StFlush, StDone} state_e;

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   asm_q, asm_d, asm_ins;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   dcnt_q, dcnt_d;
    logic               valid_q, valid_d;
    logic               live_q;
    logic               accept;

    // live_q keeps frag_ready low during reset and rises on the first edge after release.
    assign frag_ready = live_q && (state_q == StFill)
                        && !((cnt_q == CNT_W'(DEPTH - 1)) && valid_q);
    assign accept     = frag_valid && frag_ready;

    always_comb begin
        asm_ins = asm_q;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                asm_ins[k*FRAG_W +: FRAG_W] = frag_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        dcnt_d  = dcnt_q;
        valid_d = valid_q;

        if (valid_q && dct_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StFill: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(DEPTH - 1)) begin
                        buf_d   = asm_ins;
                        dcnt_d  = CNT_W'(DEPTH);
                        valid_d = 1'b1;
                        asm_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        asm_d = asm_ins;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (test_ending) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (!valid_q) begin
                    if (cnt_q != '0) begin
                        // Unused upper bits are already zero since the assembly is cleared per word.
                        buf_d   = asm_q;
                        dcnt_d  = cnt_q;
                        valid_d = 1'b1;
                        asm_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFill;
            asm_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            dcnt_q  <= '0;
            valid_q <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            dcnt_q  <= dcnt_d;
            valid_q <= valid_d;
            live_q  <= 1'b1;
        end
    end

    assign dct_valid      = valid_q;
    assign dct_buffer     = buf_q;
    assign dct_count      = dcnt_q;
    assign test_has_ended = (state_q == StDone);

endmodule
